// File: rtl/sr_mem_pkg.sv
`default_nettype none
// ============================================================================
// sr_mem_pkg : shared types and constants for the rotating-memory access port
// Revision   : 1.0
// ============================================================================
package sr_mem_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    XFER = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_e;

  localparam int         PHASES     = 8;
  localparam logic [2:0] PHASE_LAST = 3'd7;

endpackage
`default_nettype wire

// File: rtl/sr_mem_port_if.sv
`default_nettype none
// ============================================================================
// sr_mem_port_if : request/response bundle between pin logic and sr_mem_port
// Revision       : 1.0
// ============================================================================
interface sr_mem_port_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/sr_mem_slot_tracker.sv
`default_nettype none
// ============================================================================
// sr_mem_slot_tracker : mirror of the memory's bit-phase and word-slot counters
// Revision            : 1.0
// ============================================================================
module sr_mem_slot_tracker
  import sr_mem_pkg::*;
#(
  parameter int WORD_COUNT = 24,
  parameter int SLOT_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [2:0]        phase,
  output logic [SLOT_W-1:0] slot,
  output logic [SLOT_W-1:0] next_slot
);

  logic [2:0]        phase_q, phase_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    next_slot = (slot_q == SLOT_W'(WORD_COUNT - 1)) ? '0 : slot_q + 1'b1;
    phase_d   = phase_q + 3'd1;
    // The slot only advances when a full 8-bit frame has rotated past.
    slot_d    = (phase_q == PHASE_LAST) ? next_slot : slot_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 3'd0;
      slot_q  <= '0;
    end else begin
      phase_q <= phase_d;
      slot_q  <= slot_d;
    end
  end

  assign phase = phase_q;
  assign slot  = slot_q;

endmodule
`default_nettype wire

// File: rtl/sr_mem_port.sv
`default_nettype none
// ============================================================================
// sr_mem_port : parallel word requests -> serial write/din stream of the
//               8-phase rotating shift-register memory
// Revision    : 1.0
// ============================================================================
module sr_mem_port
  import sr_mem_pkg::*;
#(
  parameter int WORD_COUNT = 24,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  sr_mem_port_if.slave      bus,
  input  logic [7:0]        mem_q,
  output logic              mem_reset,
  output logic              mem_write,
  output logic              mem_din
);

  localparam logic [ADDR_W:0] WORD_LIMIT = (ADDR_W + 1)'(WORD_COUNT);

  logic [2:0]        phase;
  logic [ADDR_W-1:0] next_slot;
  logic [ADDR_W-1:0] slot_unused;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_ready;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              req_in_range;

  sr_mem_slot_tracker #(
    .WORD_COUNT (WORD_COUNT),
    .SLOT_W     (ADDR_W)
  ) u_tracker (
    .clk       (clk),
    .reset_n   (reset_n),
    .phase     (phase),
    .slot      (slot_unused),
    .next_slot (next_slot)
  );

  assign req_in_range = ({1'b0, bus.req_addr} < WORD_LIMIT);

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    mem_write = 1'b0;
    mem_din   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          // Slot match is tested on the accept cycle too, avoiding a wasted lap.
          if (!req_in_range)
            state_d = ERR;
          else if (phase == PHASE_LAST && next_slot == bus.req_addr)
            state_d = XFER;
          else
            state_d = WAIT;
        end
      end
      WAIT: begin
        if (phase == PHASE_LAST && next_slot == addr_q)
          state_d = XFER;
      end
      XFER: begin
        mem_write = we_q;
        mem_din   = we_q & wdata_q[phase];
        if (phase == PHASE_LAST)
          state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = mem_q;
        rsp_err   = 1'b0;
        rdata_d   = mem_q;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_rdata = 8'h00;
        rsp_err   = 1'b1;
        rdata_d   = 8'h00;
        err_d     = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_reset     = ~reset_n;
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_mem_port.sv
`default_nettype none
// ============================================================================
// tb_sr_mem_port : randomized self-checking bench with a cycle-level reference
// Revision       : 1.0
// ============================================================================
module tb_sr_mem_port;

  localparam int WC = 24;
  localparam int AW = 5;
  localparam int LAP = 8 * WC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sr_mem_port_if #(.ADDR_W(AW)) bus ();
  logic [7:0] mem_q;
  logic       mem_reset, mem_write, mem_din;

  sr_mem_port #(.WORD_COUNT(WC), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .mem_q     (mem_q),
    .mem_reset (mem_reset),
    .mem_write (mem_write),
    .mem_din   (mem_din)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  // Stand-in for the rotating memory: word (slot) is rewritten serially,
  // the completed word appears on mem_q when its frame ends.
  logic [7:0] mem_words [WC];
  int mph, msl;
  always @(posedge clk or posedge mem_reset) begin : mem_blk
    logic [7:0] w;
    if (mem_reset) begin
      for (int i = 0; i < WC; i++) mem_words[i] <= 8'h00;
      mph   <= 0;
      msl   <= 0;
      mem_q <= 8'h00;
    end else begin
      w = mem_words[msl];
      if (mem_write) w[mph] = mem_din;
      mem_words[msl] <= w;
      if (mph == 7) begin
        mem_q <= w;
        msl   <= (msl == WC - 1) ? 0 : msl + 1;
      end
      mph <= (mph + 1) % 8;
    end
  end

  // Reference model: absolute cycle count since reset gives phase and slot.
  int         mcyc;
  bit         act;
  int         acc, rcyc, xt;
  bit         m_we, m_err;
  logic [7:0] m_wd, m_exp;
  logic [7:0] last_rd;
  bit         last_err;
  logic [7:0] ref_mem [WC];

  function automatic int calc_start(input int a, input int addr);
    for (int t = a + 1; t <= a + LAP + 8; t++)
      if (t % 8 == 0 && (t / 8) % WC == addr) return t;
    return -1000;
  endfunction

  function bit exp_ready();
    return !(act && mcyc > acc && mcyc <= rcyc);
  endfunction

  always @(posedge clk or negedge reset_n) begin : model_blk
    int s;
    if (!reset_n) begin
      mcyc     <= 0;
      act      <= 1'b0;
      acc      <= 0;
      rcyc     <= 0;
      xt       <= -1000;
      m_we     <= 1'b0;
      m_err    <= 1'b0;
      m_wd     <= 8'h00;
      m_exp    <= 8'h00;
      last_rd  <= 8'h00;
      last_err <= 1'b0;
      for (int i = 0; i < WC; i++) ref_mem[i] <= 8'h00;
    end else begin
      if (act && mcyc == rcyc) begin
        last_rd  <= m_exp;
        last_err <= m_err;
      end
      if (bus.req_valid && exp_ready()) begin
        act  <= 1'b1;
        acc  <= mcyc;
        m_we <= bus.req_we;
        m_wd <= bus.req_wdata;
        if (int'(bus.req_addr) >= WC) begin
          m_err <= 1'b1;
          rcyc  <= mcyc + 1;
          xt    <= -1000;
          m_exp <= 8'h00;
        end else begin
          s = calc_start(mcyc, int'(bus.req_addr));
          m_err <= 1'b0;
          xt    <= s;
          rcyc  <= s + 8;
          m_exp <= bus.req_we ? bus.req_wdata : ref_mem[bus.req_addr];
          if (bus.req_we) ref_mem[bus.req_addr] <= bus.req_wdata;
        end
      end
      mcyc <= mcyc + 1;
    end
  end

  // Every-cycle comparison of all port outputs against the model.
  always @(negedge clk) begin : cmp_blk
    bit         e_valid, in_x;
    logic [7:0] e_rd;
    bit         e_err, e_din;
    if (chk_en) begin
      e_valid = act && mcyc == rcyc;
      e_rd    = e_valid ? m_exp : last_rd;
      e_err   = e_valid ? m_err : last_err;
      in_x    = act && !m_err && m_we && mcyc >= xt && mcyc < xt + 8;
      e_din   = in_x ? m_wd[mcyc - xt] : 1'b0;
      chk("mem_reset", 32'(mem_reset), 32'(!reset_n));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready()));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rd));
      chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
      chk("mem_write", 32'(mem_write), 32'(in_x));
      chk("mem_din", 32'(mem_din), 32'(e_din));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_lap_pos(input int pos);
    int n;
    n = 0;
    while ((mcyc % LAP) != pos && n < 2 * LAP) begin
      tick();
      n++;
    end
    if ((mcyc % LAP) != pos) begin
      errors++;
      $display("FAIL wait_lap_pos timeout actual=%0d required=%0d", mcyc % LAP, pos);
    end
  endtask

  // Issues one request from an idle port; returns cycle offsets from accept.
  task automatic run_req(input bit we, input int addr, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd, output bit er,
                         output int wr_first, output logic [7:0] din_byte);
    int k, idx;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = AW'(addr);
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
    k = 1; idx = 0; lat = -1; wr_first = -1; din_byte = 8'h00; rd = 8'h00; er = 1'b0;
    while (k <= LAP + 20 && lat < 0) begin
      if (mem_write) begin
        if (wr_first < 0) wr_first = k;
        if (idx < 8) din_byte[idx] = mem_din;
        idx++;
      end
      if (bus.rsp_valid) begin
        lat = k;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
      end else begin
        tick();
        k++;
      end
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL rsp_timeout actual=none required=rsp_valid addr=%0d", addr);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int         lat, wf, n;
    logic [7:0] rd, db;
    bit         er;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 8'h00;
    #1 chk_en = 1'b1;

    repeat (3) tick();
    chk("reset_mem_reset", 32'(mem_reset), 32'd1);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    reset_n = 1'b1;
    #1 chk("release_req_ready", 32'(bus.req_ready), 32'd1);

    // Write 0xA5 to slot 3, accepted at phase 0 of slot 0.
    run_req(1'b1, 3, 8'hA5, lat, rd, er, wf, db);
    chk("wr_latency", 32'(lat), 32'd32);
    chk("wr_first_write", 32'(wf), 32'd24);
    chk("wr_din_bits", 32'(db), 32'hA5);
    chk("wr_rdata", 32'(rd), 32'hA5);
    chk("wr_err", 32'(er), 32'd0);
    tick();

    run_req(1'b0, 3, 8'h00, lat, rd, er, wf, db);
    chk("rd3_rdata", 32'(rd), 32'hA5);
    chk("rd3_no_write", 32'(wf), 32'hFFFFFFFF);
    tick();
    run_req(1'b0, 10, 8'h00, lat, rd, er, wf, db);
    chk("rd10_rdata", 32'(rd), 32'h00);
    tick();

    // Slot 0 just passed its window: must wait a full lap.
    wait_lap_pos(3);
    run_req(1'b1, 0, 8'h3C, lat, rd, er, wf, db);
    chk("wrap_first_write", 32'(wf), 32'd189);
    chk("wrap_latency", 32'(lat), 32'd197);
    chk("wrap_rdata", 32'(rd), 32'h3C);
    tick();

    run_req(1'b1, 24, 8'hFF, lat, rd, er, wf, db);
    chk("oor_latency", 32'(lat), 32'd1);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", 32'(rd), 32'h00);
    chk("oor_no_write", 32'(wf), 32'hFFFFFFFF);
    tick();
    chk("oor_ready_after", 32'(bus.req_ready), 32'd1);

    // Random traffic, including requests presented while busy.
    for (int c = 0; c < 12000; c++) begin
      bus.req_valid = ($urandom_range(0, 2) == 0);
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_addr  = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, WC - 1))
                                                  : AW'($urandom_range(WC, 31));
      bus.req_wdata = 8'($urandom);
      tick();
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (!exp_ready() && n < LAP + 20) begin
      tick();
      n++;
    end
    tick();

    // Reset during XFER phase 4.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = AW'(2);
    bus.req_wdata = 8'hFF;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (mcyc != xt + 4 && n < LAP + 20) begin
      tick();
      n++;
    end
    chk("midx_writing", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midx_mem_write", 32'(mem_write), 32'd0);
    chk("midx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midx_mem_reset", 32'(mem_reset), 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    #1 chk("midx_ready", 32'(bus.req_ready), 32'd1);

    // Counters restart at phase 0 / slot 0: slot 1 is one frame away.
    run_req(1'b0, 1, 8'h00, lat, rd, er, wf, db);
    chk("post_reset_latency", 32'(lat), 32'd16);
    chk("post_reset_rdata", 32'(rd), 32'h00);
    tick();
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
